// File: rtl/tmds_pkg.sv
// tmds_pkg: shared definitions for the TMDS channel decoder.
//   - control-token encodings and the {C1,C0} value each one carries
//   - alignment FSM state type
//   - helpers: control-token lookup and 10b->8b data decode
package tmds_pkg;

  localparam logic [9:0] Tok00 = 10'b1101010100;
  localparam logic [9:0] Tok01 = 10'b0010101011;
  localparam logic [9:0] Tok10 = 10'b0101010100;
  localparam logic [9:0] Tok11 = 10'b1010101011;

  localparam logic [1:0] Ctrl00 = 2'b00;
  localparam logic [1:0] Ctrl01 = 2'b01;
  localparam logic [1:0] Ctrl10 = 2'b10;
  localparam logic [1:0] Ctrl11 = 2'b11;

  typedef enum logic [1:0] {
    StSearch,
    StSlip,
    StLocked
  } tmds_state_e;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] c;
  } tmds_ctrl_t;

  function automatic logic tmds_is_ctrl(input logic [9:0] word);
    return (word == Tok00) || (word == Tok01) || (word == Tok10) || (word == Tok11);
  endfunction

  function automatic tmds_ctrl_t tmds_ctrl_lookup(input logic [9:0] word);
    tmds_ctrl_t r;
    r.is_ctrl = 1'b1;
    r.c       = Ctrl00;
    case (word)
      Tok00:   r.c = Ctrl00;
      Tok01:   r.c = Ctrl01;
      Tok10:   r.c = Ctrl10;
      Tok11:   r.c = Ctrl11;
      default: r.is_ctrl = 1'b0;
    endcase
    return r;
  endfunction

  // Undo the TMDS transition-minimising encoding: bit 9 marks inversion,
  // bit 8 selects XOR (1) or XNOR (0) chaining.
  function automatic logic [7:0] tmds_decode8(input logic [9:0] word);
    logic [7:0] q;
    logic [7:0] d;
    q    = word[9] ? ~word[7:0] : word[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_align_window.sv
// tmds_align_window: bit-offset alignment window (pipeline stage 1).
//   clk_i, rst_ni   clock, async active-low reset
//   sym_i           raw 10-bit symbol, bit0 first on the wire
//   sym_vld_i       sym_i valid
//   ofs_i           bit offset 0..9 into {sym_i, prev}
//   pass_i          allow this symbol to be marked valid in stage 1
//   win_word_o      combinational aligned word (used by the lock FSM)
//   s1_word_o       registered aligned word
//   s1_vld_o        registered valid for s1_word_o
module tmds_align_window (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] sym_i,
  input  logic       sym_vld_i,
  input  logic [3:0] ofs_i,
  input  logic       pass_i,
  output logic [9:0] win_word_o,
  output logic [9:0] s1_word_o,
  output logic       s1_vld_o
);

  logic [9:0]  prev_q;
  logic [19:0] cat;

  // Earlier symbol sits in the low half, so offset 0 selects the previous symbol.
  assign cat = {sym_i, prev_q};

  always_comb begin
    win_word_o = cat[9:0];
    for (int k = 0; k < 10; k++) begin
      if (ofs_i == 4'(k)) begin
        win_word_o = cat[k +: 10];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= '0;
      s1_word_o <= '0;
      s1_vld_o  <= 1'b0;
    end else begin
      s1_vld_o <= sym_vld_i & pass_i;
      if (sym_vld_i) begin
        prev_q    <= sym_i;
        s1_word_o <= win_word_o;
      end
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: one TMDS receive channel.
// Slides a 10-bit window over the deserialized stream until CTRL_RUN consecutive
// control tokens appear at one offset, then decodes pixel data / control bits.
//   hdmi_pixel   pixel clock
//   rstn_i       async active-low reset
//   sym_i        raw symbol, bit0 first serial bit
//   sym_vld_i    sym_i valid
//   data_o       decoded pixel byte
//   ctrl_o       {C1,C0} from the last control token
//   de_o         data enable
//   vld_o        decoded outputs valid (two cycles after sym_vld_i)
//   locked_o     word alignment locked
//   slip_ofs_o   current bit offset 0..9
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN     = 8,
  parameter int unsigned SEARCH_WIN   = 2048,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic       hdmi_pixel,
  input  logic       rstn_i,
  input  logic [9:0] sym_i,
  input  logic       sym_vld_i,
  output logic [7:0] data_o,
  output logic [1:0] ctrl_o,
  output logic       de_o,
  output logic       vld_o,
  output logic       locked_o,
  output logic [3:0] slip_ofs_o
);

  localparam int unsigned RunW = $clog2(CTRL_RUN) + 1;
  localparam int unsigned WinW = $clog2(SEARCH_WIN) + 1;
  localparam int unsigned ToW  = $clog2(LOCK_TIMEOUT) + 1;

  tmds_state_e st_q;
  logic [RunW-1:0] run_q;
  logic [WinW-1:0] win_q;
  logic [ToW-1:0]  to_q;

  logic [9:0] win_word;
  logic [9:0] s1_word;
  logic       s1_vld;
  logic       win_tok;
  logic       timeout_fire;
  logic       stay_locked;
  tmds_ctrl_t s1_ctrl;

  assign win_tok = tmds_is_ctrl(win_word);
  assign s1_ctrl = tmds_ctrl_lookup(s1_word);

  // A token in the window always wins over an expiring timeout.
  assign timeout_fire = (st_q == StLocked) && sym_vld_i && !win_tok &&
                        (to_q == ToW'(LOCK_TIMEOUT - 1));
  // Only words that enter and leave the pipeline while locked are reported.
  assign stay_locked  = (st_q == StLocked) && !timeout_fire;

  tmds_align_window u_window (
    .clk_i      (hdmi_pixel),
    .rst_ni     (rstn_i),
    .sym_i      (sym_i),
    .sym_vld_i  (sym_vld_i),
    .ofs_i      (slip_ofs_o),
    .pass_i     (stay_locked),
    .win_word_o (win_word),
    .s1_word_o  (s1_word),
    .s1_vld_o   (s1_vld)
  );

  // Alignment FSM with its counters, offset and lock flag.
  always_ff @(posedge hdmi_pixel or negedge rstn_i) begin
    if (!rstn_i) begin
      st_q       <= StSearch;
      run_q      <= '0;
      win_q      <= '0;
      to_q       <= '0;
      slip_ofs_o <= '0;
      locked_o   <= 1'b0;
    end else begin
      unique case (st_q)
        StSearch: begin
          if (sym_vld_i) begin
            if (win_tok && (run_q == RunW'(CTRL_RUN - 1))) begin
              st_q     <= StLocked;
              locked_o <= 1'b1;
              run_q    <= '0;
              win_q    <= '0;
              to_q     <= '0;
            end else if (win_q == WinW'(SEARCH_WIN - 1)) begin
              st_q  <= StSlip;
              run_q <= '0;
              win_q <= '0;
            end else begin
              run_q <= win_tok ? run_q + RunW'(1) : '0;
              win_q <= win_q + WinW'(1);
            end
          end
        end
        StSlip: begin
          slip_ofs_o <= (slip_ofs_o == 4'd9) ? 4'd0 : slip_ofs_o + 4'd1;
          run_q      <= '0;
          win_q      <= '0;
          to_q       <= '0;
          st_q       <= StSearch;
        end
        StLocked: begin
          if (sym_vld_i) begin
            if (win_tok) begin
              to_q <= '0;
            end else if (timeout_fire) begin
              st_q     <= StSlip;
              locked_o <= 1'b0;
              to_q     <= '0;
            end else begin
              to_q <= to_q + ToW'(1);
            end
          end
        end
        default: st_q <= StSearch;
      endcase
    end
  end

  // Stage 2: registered decode. Outputs hold between valid words.
  always_ff @(posedge hdmi_pixel or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_o  <= 1'b0;
      de_o   <= 1'b0;
      data_o <= '0;
      ctrl_o <= '0;
    end else begin
      vld_o <= s1_vld && stay_locked;
      if (!stay_locked) begin
        de_o <= 1'b0;
      end else if (s1_vld) begin
        if (s1_ctrl.is_ctrl) begin
          de_o   <= 1'b0;
          ctrl_o <= s1_ctrl.c;
          data_o <= '0;
        end else begin
          de_o   <= 1'b1;
          data_o <= tmds_decode8(s1_word);
        end
      end
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed self-checking bench for tmds_channel_decoder.
// Built with CTRL_RUN=8, SEARCH_WIN=16, LOCK_TIMEOUT=32. At offset 0 the window
// shows the previous symbol, so decoded results trail the fed symbol by one.
module tb_tmds_channel_decoder;

  logic       clk;
  logic       rstn;
  logic [9:0] sym;
  logic       sym_vld;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       vld;
  logic       locked;
  logic [3:0] slip_ofs;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [9:0] T00  = 10'h354;
  localparam logic [9:0] T01  = 10'h0AB;
  localparam logic [9:0] DSym = 10'h100;  // decodes to 0x00
  localparam logic [9:0] Rot3 = 10'h2A6;  // 0x354 rotated so it aligns at offset 3

  tmds_channel_decoder #(
    .CTRL_RUN     (8),
    .SEARCH_WIN   (16),
    .LOCK_TIMEOUT (32)
  ) dut (
    .hdmi_pixel (clk),
    .rstn_i     (rstn),
    .sym_i      (sym),
    .sym_vld_i  (sym_vld),
    .data_o     (data),
    .ctrl_o     (ctrl),
    .de_o       (de),
    .vld_o      (vld),
    .locked_o   (locked),
    .slip_ofs_o (slip_ofs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one symbol, clock it in, sample 1 time unit after the edge.
  task automatic step(input logic [9:0] s, input logic v);
    sym     = s;
    sym_vld = v;
    @(posedge clk);
    #1;
  endtask

  // Feed s continuously until the offset changes; 16 counted symbols + 1 SLIP cycle.
  task automatic wait_slip(input string tag, input logic [9:0] s, input logic [3:0] exp);
    logic [3:0] start;
    int n;
    start = slip_ofs;
    n     = 0;
    do begin
      step(s, 1'b1);
      n++;
    end while (slip_ofs == start && n < 40);
    check({tag, "_ofs"}, 32'(slip_ofs), 32'(exp));
    check({tag, "_gap"}, 32'(n), 32'd17);
  endtask

  initial begin
    rstn    = 1'b0;
    sym     = '0;
    sym_vld = 1'b0;

    // Reset: outputs held at zero regardless of input activity.
    for (int i = 0; i < 6; i++) begin
      sym     = 10'($urandom);
      sym_vld = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset_outs", {15'd0, data, ctrl, de, vld, locked, slip_ofs}, 32'd0);
    end
    rstn = 1'b1;

    // Fast lock: edge 1 sees prev=0, edges 2..9 see the token.
    for (int i = 0; i < 8; i++) step(T00, 1'b1);
    check("lock_pre", 32'(locked), 32'd0);
    step(T00, 1'b1);
    check("lock_9th", 32'(locked), 32'd1);
    check("lock_vld_early", 32'(vld), 32'd0);
    step(T00, 1'b1);
    check("lock_vld_1", 32'(vld), 32'd0);
    step(T00, 1'b1);
    check("lock_vld_2", 32'(vld), 32'd1);
    check("lock_ctrl", 32'(ctrl), 32'd0);
    check("lock_de", 32'(de), 32'd0);

    // Decode: 0x100 -> 0x00, 0x2FF -> 0xFE, 0x0AB -> ctrl 01.
    step(DSym, 1'b1);
    step(10'h2FF, 1'b1);
    step(T01, 1'b1);
    check("dec0_data", 32'(data), 32'h00);
    check("dec0_de", 32'(de), 32'd1);
    check("dec0_vld", 32'(vld), 32'd1);
    step(T00, 1'b1);
    check("dec1_data", 32'(data), 32'hFE);
    check("dec1_de", 32'(de), 32'd1);
    check("dec1_ctrl_hold", 32'(ctrl), 32'd0);
    step(T00, 1'b1);
    check("dec2_de", 32'(de), 32'd0);
    check("dec2_ctrl", 32'(ctrl), 32'd1);
    check("dec2_data", 32'(data), 32'h00);

    // Token lands on the would-be timeout cycle: no slip.
    step(T00, 1'b1);
    for (int i = 0; i < 31; i++) step(DSym, 1'b1);
    step(T00, 1'b1);
    step(T00, 1'b1);
    check("tie_locked", 32'(locked), 32'd1);
    step(T00, 1'b1);
    check("tie_locked2", 32'(locked), 32'd1);

    // Timeout with sym_vld gaps: 32nd non-token window word drops lock.
    for (int k = 1; k <= 32; k++) begin
      step(DSym, 1'b1);
      if (k % 4 == 0) step(DSym, 1'b0);
    end
    check("to_before", 32'(locked), 32'd1);
    step(DSym, 1'b1);
    check("to_locked", 32'(locked), 32'd0);
    check("to_vld", 32'(vld), 32'd0);
    check("to_de", 32'(de), 32'd0);
    check("to_ofs_hold", 32'(slip_ofs), 32'd0);
    step(10'h000, 1'b1);
    check("to_ofs_inc", 32'(slip_ofs), 32'd1);

    // Wrap: idle stream slips 1 -> 9 -> 0.
    for (int k = 2; k <= 10; k++) begin
      wait_slip((k == 10) ? "wrap_9to0" : "wrap", 10'h000, 4'(k % 10));
    end
    check("wrap_unlocked", 32'(locked), 32'd0);

    // Slip search from fresh reset on a stream aligned at offset 3.
    rstn = 1'b0;
    step(Rot3, 1'b0);
    check("rst2_ofs", 32'(slip_ofs), 32'd0);
    rstn = 1'b1;
    wait_slip("slip1", Rot3, 4'd1);
    wait_slip("slip2", Rot3, 4'd2);
    wait_slip("slip3", Rot3, 4'd3);
    for (int i = 0; i < 7; i++) step(Rot3, 1'b1);
    check("slip_lock_pre", 32'(locked), 32'd0);
    step(Rot3, 1'b1);
    check("slip_lock", 32'(locked), 32'd1);
    step(Rot3, 1'b1);
    step(Rot3, 1'b1);
    check("slip_vld", 32'(vld), 32'd1);
    check("slip_ctrl", 32'(ctrl), 32'd0);
    check("slip_de", 32'(de), 32'd0);

    // Asynchronous reset mid-LOCKED, checked before any clock edge.
    #3;
    rstn = 1'b0;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_ofs", 32'(slip_ofs), 32'd0);
    check("arst_vld", 32'(vld), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
